// File: rtl/approx_err_monitor.sv
// ---------------------------------------------------------------------------
// approx_err_monitor
//
// Measures the accuracy of an approximate adder over a run of n_samples
// operand pairs. Each accepted sample (in1, in2, approx_sum) is compared with
// the exact sum; the absolute error is accumulated into a sum (sae), a running
// maximum (max_err), a count of erroneous samples (err_cnt) and a sample
// count (sample_cnt).
//
// Pipeline: acceptance edge registers the sample, stage 1 registers the
// absolute error, stage 2 updates the accumulators. A sample accepted at
// edge t is reflected in the result outputs after edge t+2.
//
// Ports
//   clk, rst_n   : clock, asynchronous active-low reset
//   start        : begin a run (honoured in IDLE only); latches n_samples
//   abort        : end the run at once, drop in-flight samples, no done
//   n_samples    : number of samples in the run
//   in_valid     : sample present on in1/in2/approx_sum
//   in_ready     : block accepts a sample this cycle
//   in1, in2     : operands fed to the approximate adder
//   approx_sum   : approximate adder result (WIDTH+1 bits)
//   busy         : high while running or draining
//   done         : one-cycle pulse when results are final
//   sae          : sum of absolute errors
//   max_err      : largest absolute error
//   err_cnt      : number of samples with nonzero error
//   sample_cnt   : number of samples accumulated
// ---------------------------------------------------------------------------
module approx_err_monitor #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic                   abort,
    input  logic [CNT_W-1:0]       n_samples,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [WIDTH-1:0]       in1,
    input  logic [WIDTH-1:0]       in2,
    input  logic [WIDTH:0]         approx_sum,
    output logic                   busy,
    output logic                   done,
    output logic [CNT_W+WIDTH:0]   sae,
    output logic [WIDTH:0]         max_err,
    output logic [CNT_W-1:0]       err_cnt,
    output logic [CNT_W-1:0]       sample_cnt
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t               state_q,     state_d;
    logic [CNT_W-1:0]     n_q,         n_d;
    logic [CNT_W-1:0]     acc_q,       acc_d;        // samples accepted so far
    logic                 smp_valid_q, smp_valid_d;  // registered-sample stage
    logic [WIDTH-1:0]     in1_q,       in1_d;
    logic [WIDTH-1:0]     in2_q,       in2_d;
    logic [WIDTH:0]       approx_q,    approx_d;
    logic                 err_valid_q, err_valid_d;  // error stage
    logic [WIDTH:0]       err_q,       err_d;
    logic [CNT_W+WIDTH:0] sae_q,       sae_d;
    logic [WIDTH:0]       max_q,       max_d;
    logic [CNT_W-1:0]     errc_q,      errc_d;
    logic [CNT_W-1:0]     cnt_q,       cnt_d;

    logic                 accept;
    logic [WIDTH:0]       exact;

    assign in_ready = (state_q == ST_RUN) && (acc_q < n_q);
    assign busy     = (state_q == ST_RUN) || (state_q == ST_DRAIN);
    // abort in DONE returns to IDLE without ever showing the pulse.
    assign done     = (state_q == ST_DONE) && !abort;
    assign sae        = sae_q;
    assign max_err    = max_q;
    assign err_cnt    = errc_q;
    assign sample_cnt = cnt_q;

    // NOTE: every signal written here gets a default first, so no path leaves
    // it unassigned and no latch is inferred.
    always_comb begin
        state_d     = state_q;
        n_d         = n_q;
        acc_d       = acc_q;
        in1_d       = in1_q;
        in2_d       = in2_q;
        approx_d    = approx_q;
        sae_d       = sae_q;
        max_d       = max_q;
        errc_d      = errc_q;
        cnt_d       = cnt_q;

        // abort outranks acceptance.
        accept      = in_valid && in_ready && !abort;

        // Sample register.
        smp_valid_d = accept;
        if (accept) begin
            in1_d    = in1;
            in2_d    = in2;
            approx_d = approx_sum;
        end

        // Stage 1: absolute error against the zero-extended exact sum.
        exact       = {1'b0, in1_q} + {1'b0, in2_q};
        err_valid_d = smp_valid_q;
        err_d       = (approx_q >= exact) ? (approx_q - exact) : (exact - approx_q);

        // Stage 2: accumulate.
        if (err_valid_q) begin
            sae_d  = sae_q + {{CNT_W{1'b0}}, err_q};
            max_d  = (err_q > max_q) ? err_q : max_q;
            errc_d = errc_q + {{(CNT_W-1){1'b0}}, (err_q != '0)};
            cnt_d  = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end

        unique case (state_q)
            ST_IDLE: begin
                // start wins over a simultaneous abort here.
                if (start) begin
                    n_d     = n_samples;
                    acc_d   = '0;
                    sae_d   = '0;
                    max_d   = '0;
                    errc_d  = '0;
                    cnt_d   = '0;
                    state_d = (n_samples != '0) ? ST_RUN : ST_DONE;
                end
            end
            ST_RUN: begin
                if (accept) begin
                    acc_d = acc_q + {{(CNT_W-1){1'b0}}, 1'b1};
                    if (acc_d == n_q) state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                // Once the sample register is empty, the error stage drains
                // into the accumulators on this very edge.
                if (!smp_valid_q) state_d = ST_DONE;
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        if (abort && (state_q != ST_IDLE)) begin
            state_d     = ST_IDLE;
            smp_valid_d = 1'b0;
            err_valid_d = 1'b0;
            sae_d       = sae_q;
            max_d       = max_q;
            errc_d      = errc_q;
            cnt_d       = cnt_q;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            n_q         <= '0;
            acc_q       <= '0;
            smp_valid_q <= 1'b0;
            err_valid_q <= 1'b0;
            sae_q       <= '0;
            max_q       <= '0;
            errc_q      <= '0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            n_q         <= n_d;
            acc_q       <= acc_d;
            smp_valid_q <= smp_valid_d;
            err_valid_q <= err_valid_d;
            sae_q       <= sae_d;
            max_q       <= max_d;
            errc_q      <= errc_d;
            cnt_q       <= cnt_d;
        end
    end

    // NOTE: datapath registers carry no reset; their contents are only used
    // when the matching valid bit, which is reset, is set.
    always_ff @(posedge clk) begin
        in1_q    <= in1_d;
        in2_q    <= in2_d;
        approx_q <= approx_d;
        err_q    <= err_d;
    end

endmodule

// File: tb/tb_approx_err_monitor.sv
// ---------------------------------------------------------------------------
// tb_approx_err_monitor
//
// Directed bench for approx_err_monitor. Each run that should end in a done
// pulse pushes its hand-computed results into a queue; an independent
// monitor pops and compares on every done pulse, and flags any done pulse
// with nothing expected (abort / reset runs).
// ---------------------------------------------------------------------------
module tb_approx_err_monitor;

    localparam int WIDTH = 16;
    localparam int CNT_W = 32;

    logic                 clk;
    logic                 rst_n;
    logic                 start;
    logic                 abort;
    logic [CNT_W-1:0]     n_samples;
    logic                 in_valid;
    logic                 in_ready;
    logic [WIDTH-1:0]     in1;
    logic [WIDTH-1:0]     in2;
    logic [WIDTH:0]       approx_sum;
    logic                 busy;
    logic                 done;
    logic [CNT_W+WIDTH:0] sae;
    logic [WIDTH:0]       max_err;
    logic [CNT_W-1:0]     err_cnt;
    logic [CNT_W-1:0]     sample_cnt;

    approx_err_monitor #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .abort      (abort),
        .n_samples  (n_samples),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in1        (in1),
        .in2        (in2),
        .approx_sum (approx_sum),
        .busy       (busy),
        .done       (done),
        .sae        (sae),
        .max_err    (max_err),
        .err_cnt    (err_cnt),
        .sample_cnt (sample_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [CNT_W+WIDTH:0] sae;
        logic [WIDTH:0]       max_err;
        logic [CNT_W-1:0]     err_cnt;
        logic [CNT_W-1:0]     sample_cnt;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   rdy_cycles = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    task automatic push_exp(input logic [CNT_W+WIDTH:0] s, input logic [WIDTH:0] m,
                            input logic [CNT_W-1:0] e, input logic [CNT_W-1:0] c);
        exp_t x;
        x.sae = s; x.max_err = m; x.err_cnt = e; x.sample_cnt = c;
        exp_q.push_back(x);
    endtask

    // Monitor: compares results on each done pulse.
    always @(negedge clk) begin
        if (in_ready) rdy_cycles++;
        if (done) begin
            if (exp_q.size() == 0) begin
                check("unexpected_done", 64'd1, 64'd0);
            end else begin
                exp_t x;
                x = exp_q.pop_front();
                check("sae",        64'(sae),        64'(x.sae));
                check("max_err",    64'(max_err),    64'(x.max_err));
                check("err_cnt",    64'(err_cnt),    64'(x.err_cnt));
                check("sample_cnt", 64'(sample_cnt), 64'(x.sample_cnt));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [CNT_W-1:0] n);
        start     = 1'b1;
        n_samples = n;
        tick();
        start     = 1'b0;
        n_samples = 32'hDEAD_BEEF;  // must be ignored outside the start cycle
    endtask

    // Present a sample and hold it until an edge accepts it; leaves in_valid high.
    task automatic send(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input logic [WIDTH:0] s);
        logic r;
        logic got;
        got        = 1'b0;
        in_valid   = 1'b1;
        in1        = a;
        in2        = b;
        approx_sum = s;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            r = in_ready;
            tick();
            if (r) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) check("send_timeout", 64'd0, 64'd1);
    endtask

    task automatic wait_done(input int budget);
        logic seen;
        seen = 1'b0;
        for (int k = 0; k < budget; k++) begin
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) check("done_timeout", 64'd0, 64'd1);
        tick();
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_in_ready"},   64'(in_ready),   64'd0);
        check({tag, "_busy"},       64'(busy),       64'd0);
        check({tag, "_done"},       64'(done),       64'd0);
        check({tag, "_sae"},        64'(sae),        64'd0);
        check({tag, "_max_err"},    64'(max_err),    64'd0);
        check({tag, "_err_cnt"},    64'(err_cnt),    64'd0);
        check({tag, "_sample_cnt"}, 64'(sample_cnt), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n      = 1'b0;
        start      = 1'b0;
        abort      = 1'b0;
        n_samples  = '0;
        in_valid   = 1'b0;
        in1        = '0;
        in2        = '0;
        approx_sum = '0;

        // Reset state.
        repeat (2) @(posedge clk);
        #2;
        check_all_zero("reset");
        rst_n = 1'b1;

        // n=1: 3+5 approximated as 5 -> error 3; start on first edge after release.
        push_exp(3, 3, 1, 1);
        do_start(1);
        check("first_start_busy", 64'(busy), 64'd1);
        send(16'd3, 16'd5, 17'd5);
        in_valid = 1'b0;
        @(negedge clk); check("lat_done_t0", 64'(done), 64'd0);
        @(negedge clk); check("lat_done_t1", 64'(done), 64'd0);
        @(negedge clk); check("lat_done_t2", 64'(done), 64'd1);
        repeat (3) tick();
        check("hold_sae",  64'(sae),  64'd3);
        check("hold_busy", 64'(busy), 64'd0);

        // n=3 back-to-back; a stray start mid-run must be ignored.
        rdy_cycles = 0;
        push_exp(49'h10000, 17'h10000, 1, 3);
        do_start(3);
        send(16'h0001, 16'h0001, 17'h00002);
        start     = 1'b1;
        n_samples = 9;
        send(16'hFFFF, 16'h0001, 17'h10000);
        send(16'h8000, 16'h8000, 17'h00000);
        start     = 1'b0;
        in_valid  = 1'b0;
        wait_done(10);
        check("b2b_rdy_cycles", 64'(rdy_cycles), 64'd3);

        // n=0: done on the next cycle, nothing accepted.
        rdy_cycles = 0;
        push_exp(0, 0, 0, 0);
        do_start(0);
        @(negedge clk);
        check("n0_done", 64'(done), 64'd1);
        tick();
        check("n0_rdy_cycles", 64'(rdy_cycles), 64'd0);

        // n=4 with in_valid on even cycles; errors 0,2,5,1; the 5th is ignored.
        rdy_cycles = 0;
        push_exp(8, 5, 3, 4);
        do_start(4);
        for (int i = 0; i < 10; i++) begin
            in1 = 16'(i * 16);
            in2 = 16'd1;
            case (i)
                0:       approx_sum = 17'd1;
                2:       approx_sum = 17'd35;
                4:       approx_sum = 17'd60;
                6:       approx_sum = 17'd98;
                8:       approx_sum = 17'd229;
                default: approx_sum = 17'h1FFFF;
            endcase
            in_valid = (i % 2 == 0);
            if (i == 7) begin
                @(negedge clk);
                check("toggle_ready_after_4th", 64'(in_ready), 64'd0);
            end
            tick();
        end
        in_valid = 1'b0;
        tick();
        check("toggle_rdy_cycles", 64'(rdy_cycles), 64'd7);

        // Abort one cycle after the 2nd of 5 samples; no done must follow.
        do_start(5);
        send(16'd1, 16'd1, 17'd5);
        send(16'd1, 16'd1, 17'd5);
        in_valid = 1'b0;
        tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_cnt_le2", 64'(sample_cnt <= 2), 64'd1);
        repeat (5) tick();
        // start with abort held in IDLE: start wins and clears the results.
        push_exp(0, 0, 0, 1);
        abort = 1'b1;
        do_start(1);
        abort = 1'b0;
        check("restart_busy",   64'(busy),       64'd1);
        check("restart_sae",    64'(sae),        64'd0);
        check("restart_errcnt", 64'(err_cnt),    64'd0);
        check("restart_cnt",    64'(sample_cnt), 64'd0);
        send(16'd10, 16'd10, 17'd20);
        in_valid = 1'b0;
        wait_done(10);

        // Reset mid-run with two samples in flight.
        do_start(5);
        send(16'd7, 16'd7, 17'd1);
        send(16'd7, 16'd7, 17'd2);
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("midrun_reset");
        tick();
        #3;
        rst_n = 1'b1;
        repeat (6) tick();
        check("post_reset_busy", 64'(busy), 64'd0);

        check("pending_results", 64'(exp_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/approx_err_monitor.md
APPROX_ERR_MONITOR -- requirements
Module: approx_err_monitor

Interface
REQ-001 Parameter WIDTH, default 16: operand width of the adder under test.
REQ-002 Parameter CNT_W, default 32: width of the sample and error counters.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst_n  input  1  reset; asynchronous, active-low.
REQ-005 start  input  1  begin a measurement run; honoured only in IDLE.
REQ-006 abort  input  1  terminate the run, discard in-flight samples, no done pulse.
REQ-007 n_samples  input  CNT_W  number of samples in the run, latched on accepted start.
REQ-008 in_valid  input  1  sample present on in1/in2/approx_sum.
REQ-009 in_ready  output  1  block accepts a sample this cycle.
REQ-010 in1, in2  input  WIDTH each  operands applied to the approximate adder.
REQ-011 approx_sum  input  WIDTH+1  result produced by the approximate adder.
REQ-012 busy  output  1  high in RUN and DRAIN.
REQ-013 done  output  1  one-cycle pulse when results are final.
REQ-014 sae  output  CNT_W+WIDTH+1  sum of absolute errors.
REQ-015 max_err  output  WIDTH+1  largest absolute error seen.
REQ-016 err_cnt  output  CNT_W  samples with nonzero error.
REQ-017 sample_cnt  output  CNT_W  samples accumulated.

Function
REQ-018 FSM states SHALL be IDLE, RUN, DRAIN, DONE.
REQ-019 IDLE + start: clear sae/max_err/err_cnt/sample_cnt, latch n_samples; go RUN if n_samples!=0, else DONE.
REQ-020 in_ready SHALL be 1 only in RUN while accepted count < latched n_samples; 0 in all other states.
REQ-021 A sample is accepted when in_valid & in_ready; in_valid without in_ready SHALL have no effect.
REQ-022 Stage 1 (registered): exact = in1 + in2 at WIDTH+1 bits, zero-extended; err = |approx_sum - exact| as an unsigned WIDTH+1 value.
REQ-023 Stage 2 (registered): sae += err; max_err = max(max_err, err); err_cnt += (err!=0); sample_cnt += 1.
REQ-024 Latency: a sample accepted at edge t SHALL be visible in the outputs after edge t+2.
REQ-025 Back-to-back acceptance SHALL be sustained at one sample per cycle with no bubbles.
REQ-026 When the n-th sample is accepted: RUN -> DRAIN; in_ready low from the next cycle.
REQ-027 DRAIN lasts until both pipeline stages are empty (2 cycles), then DONE.
REQ-028 DONE: done=1 for exactly one cycle, then IDLE; results SHALL hold until the next accepted start.
REQ-029 start outside IDLE SHALL be ignored; n_samples changes outside the start cycle SHALL be ignored.
REQ-030 abort in RUN/DRAIN/DONE: next state IDLE, pipeline valid bits cleared, done not asserted; partial results hold. abort SHALL take priority over start and acceptance. abort in IDLE has no effect.
REQ-031 Counters and sae SHALL NOT saturate; wrap is unreachable for n_samples < 2^CNT_W by width choice.
REQ-032 If start and abort are both asserted in IDLE, start wins.

Reset
REQ-033 While rst_n=0: state IDLE; in_ready, busy, done = 0; sae, max_err, err_cnt, sample_cnt = 0; pipeline valid bits = 0.
REQ-034 Reset mid-run SHALL discard all in-flight samples; no done pulse follows release.
REQ-035 The first start SHALL be honoured on the first rising edge after rst_n deasserts.

Verification
REQ-036 n=1, in1=3, in2=5, approx_sum=5 -> done 3 cycles after acceptance; sae=3, max_err=3, err_cnt=1, sample_cnt=1.
REQ-037 n=3, back-to-back samples (0x0001,0x0001,0x00002), (0xFFFF,0x0001,0x10000), (0x8000,0x8000,0x00000) -> sae=0x10000, max_err=0x10000, err_cnt=1, sample_cnt=3, in_ready 1 for exactly 3 cycles.
REQ-038 n=0 start -> done one cycle later, all results 0, in_ready never high.
REQ-039 n=4 with in_valid toggling every other cycle -> exactly 4 samples counted; in_ready low after the 4th; extra in_valid is ignored.
REQ-040 abort one cycle after the 2nd of n=5 accepted samples -> IDLE, no done pulse, sample_cnt<=2; next start clears all results.
REQ-041 rst_n low mid-RUN with 2 samples in flight -> all outputs 0 asynchronously; no done pulse after release.
